// File: rtl/carregador_instrucoes_pkg.sv
// Shared definitions for the instruction loader: loader states and word geometry.
// Imported by the top-level loader and its word assembler.
package carregador_instrucoes_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } estado_t;

endpackage

// File: rtl/carregador_instrucoes_montador.sv
// Little-endian word assembler: places each loaded byte into the next byte lane.
// word_full flags that the next load completes the word.
module montador_palavra
  import carregador_instrucoes_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        byte_data,
  output logic [DATA_W-1:0] word,
  output logic              word_full
);

  logic [BYTE_IDX_W-1:0] idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      idx  <= '0;
      word <= '0;
    end else if (load) begin
      word[{idx, 3'b000} +: 8] <= byte_data;
      idx                      <= idx + 1'b1;
    end
  end

  assign word_full = (idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/carregador_instrucoes.sv
// Instruction-memory loader: assembles a byte stream into words, writes them from address 0,
// and holds the core until the all-zero halt word has been written.
module carregador_instrucoes
  import carregador_instrucoes_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  estado_t             state, state_nxt;
  logic                clear, load;
  logic [DATA_W-1:0]   word;
  logic                word_full;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   addr_last;
  logic [DATA_W-1:0]   wdata_last;
  logic                word_zero;
  logic                addr_last_slot;

  montador_palavra #(
    .DATA_W (DATA_W)
  ) u_montador (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load      (load),
    .byte_data (byte_data),
    .word      (word),
    .word_full (word_full)
  );

  assign word_zero      = (word == '0);
  assign addr_last_slot = &addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    load      = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_nxt = ST_RECV;
          clear     = 1'b1;
        end
      end
      ST_RECV: begin
        if (byte_valid) begin
          load = 1'b1;
          if (word_full) state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (word_zero)           state_nxt = ST_DONE;
        else if (addr_last_slot) state_nxt = ST_ERR;
        else                     state_nxt = ST_RECV;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address/count bookkeeping; last-write registers keep the memory bus stable between strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr       <= '0;
      addr_last  <= '0;
      wdata_last <= '0;
      word_count <= '0;
    end else if (clear) begin
      addr       <= '0;
      word_count <= '0;
    end else if (state == ST_WRITE) begin
      addr_last  <= addr;
      wdata_last <= word;
      word_count <= word_count + 1'b1;
      if (!word_zero && !addr_last_slot) addr <= addr + 1'b1;
    end
  end

  assign byte_ready = (state == ST_RECV);
  assign imem_we    = (state == ST_WRITE);
  assign imem_addr  = imem_we ? addr : addr_last;
  assign imem_wdata = imem_we ? word : wdata_last;
  assign cpu_hold   = (state != ST_DONE);
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_ERR);

endmodule

// File: tb/tb_carregador_instrucoes.sv
// Self-checking bench for carregador_instrucoes: table-driven programs, hand corner cases, random loads.
module tb_carregador_instrucoes;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  carregador_instrucoes #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0]       prog[$];
  logic [7:0]        bq[$];
  int                bi;
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];

  typedef struct {
    int          nw;
    logic [31:0] w[4];
    int          gap;
    int          cnt;
  } vec_t;
  vec_t tbl[5];

  always @(negedge clk) begin
    if (rst && imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_pulse();
    logic [31:0] w;
    @(negedge clk);
    wa.delete();
    wd.delete();
    bq.delete();
    foreach (prog[i]) begin
      w = prog[i];
      for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
    end
    bi = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_state", 64'({done, error, cpu_hold, byte_ready}), 64'(4'b0011));
  endtask

  task automatic feed(input int nbytes, input int gap);
    bit give;
    bit tog;
    int cyc;
    tog = 1'b1;
    cyc = 0;
    if (nbytes > bq.size()) nbytes = bq.size();
    while (bi < nbytes && !done && !error && cyc < 4000) begin
      if (gap == 0)      give = 1'b1;
      else if (gap == 1) give = tog;
      else               give = 1'($urandom_range(0, 1));
      tog        = ~tog;
      byte_valid = give;
      byte_data  = give ? bq[bi] : 8'($urandom);
      if (give && byte_ready) bi++;
      @(negedge clk);
      cyc++;
    end
    byte_valid = 1'b0;
  endtask

  task automatic finish_check(input int tbl_cnt);
    int  exp_n;
    bit  term;
    int  m;
    int  cyc;
    cyc = 0;
    while (!done && !error && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("finished", 64'(done | error), 64'(1));
    repeat (6) @(negedge clk);
    exp_n = 0;
    term  = 1'b0;
    foreach (prog[i]) begin
      exp_n++;
      if (prog[i] == 32'h0) begin
        term = 1'b1;
        break;
      end
      if (exp_n == 32) break;
    end
    chk("n_writes", 64'(wa.size()), 64'(exp_n));
    m = (wa.size() < exp_n) ? wa.size() : exp_n;
    for (int i = 0; i < m; i++) begin
      chk($sformatf("waddr[%0d]", i), 64'(wa[i]), 64'(i));
      chk($sformatf("wdata[%0d]", i), 64'(wd[i]), 64'(prog[i]));
    end
    chk("flags", 64'({done, error, cpu_hold}), term ? 64'(3'b100) : 64'(3'b011));
    chk("word_count", 64'(word_count), 64'(exp_n));
    if (tbl_cnt >= 0) chk("tbl_count", 64'(word_count), 64'(tbl_cnt));
  endtask

  task automatic chk_reset_values(input string nm);
    chk({nm, "_ctl"}, 64'({byte_ready, imem_we, cpu_hold, done, error}), 64'(5'b00100));
    chk({nm, "_cnt"}, 64'(word_count), 64'(0));
    chk({nm, "_addr"}, 64'(imem_addr), 64'(0));
    chk({nm, "_wdata"}, 64'(imem_wdata), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    tbl[0] = '{nw: 2, w: '{32'h00A00513, 32'h0, 32'h0, 32'h0}, gap: 0, cnt: 2};
    tbl[1] = '{nw: 2, w: '{32'h00A00513, 32'h0, 32'h0, 32'h0}, gap: 1, cnt: 2};
    tbl[2] = '{nw: 1, w: '{32'h0, 32'h0, 32'h0, 32'h0}, gap: 0, cnt: 1};
    tbl[3] = '{nw: 3, w: '{32'h11111111, 32'h00000100, 32'h0, 32'h0}, gap: 2, cnt: 3};
    tbl[4] = '{nw: 2, w: '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, gap: 0, cnt: 1};

    repeat (2) @(negedge clk);
    chk_reset_values("reset_init");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_hold", 64'({byte_ready, cpu_hold, done}), 64'(3'b010));

    for (int t = 0; t < 5; t++) begin
      prog.delete();
      for (int j = 0; j < tbl[t].nw; j++) prog.push_back(tbl[t].w[j]);
      start_pulse();
      feed(bq.size(), tbl[t].gap);
      finish_check(tbl[t].cnt);
    end

    // 33 nonzero words: memory fills, error, 33rd word never consumed
    prog.delete();
    for (int i = 0; i < 33; i++) prog.push_back($urandom | 32'h0000_0100);
    start_pulse();
    feed(bq.size(), 0);
    finish_check(32);

    // async reset in the middle of word 1, then a fresh program
    prog.delete();
    prog.push_back(32'h11223344);
    prog.push_back(32'h55667788);
    prog.push_back(32'h0);
    start_pulse();
    feed(6, 0);
    #2 rst = 1'b0;
    #1 chk_reset_values("reset_async");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    prog.delete();
    prog.push_back(32'hCAFEF00D);
    prog.push_back(32'h0BADC0DE);
    prog.push_back(32'h0);
    start_pulse();
    feed(bq.size(), 0);
    finish_check(3);

    for (int r = 0; r < 5; r++) begin
      prog.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++) begin
        for (int k = 0; k < 4; k++)
          w[8*k +: 8] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        if (w == 32'h0) w = 32'h1;
        prog.push_back(w);
      end
      prog.push_back(32'h0);
      for (int i = 0; i < $urandom_range(0, 2); i++) prog.push_back($urandom);
      start_pulse();
      feed(bq.size(), 2);
      finish_check(-1);
    end

    // latency: write strobe the cycle after the 4th byte, then DONE
    prog.delete();
    prog.push_back(32'h0);
    start_pulse();
    for (int k = 0; k < 4; k++) begin
      byte_valid = 1'b1;
      byte_data  = 8'h00;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk("lat_we", 64'({imem_we, byte_ready, done}), 64'(3'b100));
    chk("lat_addr", 64'(imem_addr), 64'(0));
    @(negedge clk);
    chk("lat_done", 64'({done, cpu_hold, imem_we}), 64'(3'b100));
    chk("lat_writes", 64'(wa.size()), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
